// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a two-entry (output + skid) valid/ready buffer.
// Optional SHAMT/ZIMM decode is compiled in when IMM_GEN_EXT_IMM_EN is defined.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [2:0] SEL_R     = 3'd0;
  localparam logic [2:0] SEL_I     = 3'd1;
  localparam logic [2:0] SEL_S     = 3'd2;
  localparam logic [2:0] SEL_B     = 3'd3;
  localparam logic [2:0] SEL_J     = 3'd4;
  localparam logic [2:0] SEL_U     = 3'd5;
`ifdef IMM_GEN_EXT_IMM_EN
  localparam logic [2:0] SEL_SHAMT = 3'd6;
  localparam logic [2:0] SEL_ZIMM  = 3'd7;
`endif

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    imm_q, imm_d, skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0]   tag_q, tag_d, skid_tag_q, skid_tag_d;
  logic [XLEN-1:0]    dec_imm_c;
  logic               accept_c, pop_c;

  // Signed views of each format; a sized cast of a signed value sign-extends from inst[31].
  logic signed [11:0] i_imm_c, s_imm_c;
  logic signed [12:0] b_imm_c;
  logic signed [20:0] j_imm_c;
  logic signed [31:0] u_imm_c;
  logic               unused_c;

  assign i_imm_c  = inst[31:20];
  assign s_imm_c  = {inst[31:25], inst[11:7]};
  assign b_imm_c  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign j_imm_c  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign u_imm_c  = {inst[31:12], 12'b0};
  assign unused_c = ^inst[6:0];

`ifdef IMM_GEN_EXT_IMM_EN
  logic [5:0] shamt_c;
  assign shamt_c = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
`endif

  // Format decode
  always_comb begin
    dec_imm_c = '0;
    case (imm_sel)
      SEL_R:     dec_imm_c = '0;
      SEL_I:     dec_imm_c = XLEN'(i_imm_c);
      SEL_S:     dec_imm_c = XLEN'(s_imm_c);
      SEL_B:     dec_imm_c = XLEN'(b_imm_c);
      SEL_J:     dec_imm_c = XLEN'(j_imm_c);
      SEL_U:     dec_imm_c = XLEN'(u_imm_c);
`ifdef IMM_GEN_EXT_IMM_EN
      SEL_SHAMT: dec_imm_c = XLEN'(shamt_c);
      SEL_ZIMM:  dec_imm_c = XLEN'(inst[19:15]);
`endif
      default:   dec_imm_c = '0;
    endcase
  end

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = out_valid_q & out_ready;

  // Buffer next-state; FULL never accepts because in_ready_q is low there
  always_comb begin
    state_d    = state_q;
    imm_d      = imm_q;
    tag_d      = tag_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          imm_d   = dec_imm_c;
          tag_d   = in_tag;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept_c && pop_c) begin
          imm_d = dec_imm_c;
          tag_d = in_tag;
        end else if (accept_c) begin
          skid_imm_d = dec_imm_c;
          skid_tag_d = in_tag;
          state_d    = FULL;
        end else if (pop_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop_c) begin
          imm_d   = skid_imm_q;
          tag_d   = skid_tag_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      tag_q       <= '0;
      skid_imm_q  <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      tag_q       <= tag_d;
      skid_imm_q  <= skid_imm_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = imm_q;
  assign out_tag   = tag_q;

endmodule
